// File: rtl/mem_channel_sched.sv
// mem_channel_sched: round-robin scheduler sharing one memory channel, one transaction in flight.
// Define MEM_CHANNEL_SCHED_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES.
module mem_channel_sched #(
  parameter int NUM_USERS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_USERS-1:0]             req_valid,
  input  logic [NUM_USERS-1:0]             req_we,
  input  logic [NUM_USERS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_USERS*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_USERS-1:0]             req_ready,
  output logic [NUM_USERS-1:0]             req_resp_valid,
  output logic [DATA_WIDTH-1:0]            req_resp_data,
  output logic                             req_resp_err,
  output logic                             mem_valid,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data,
  input  logic                             mem_ready,
  input  logic                             mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_resp_data
);
  localparam int UW = $clog2(NUM_USERS);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;
  state_t state_q, state_d;
  logic [UW-1:0] ptr_q, ptr_d, uid_q, uid_d, off, sel;
  logic [UW:0] sum;
  logic [2*NUM_USERS-1:0] dbl;
  logic found, we_q, we_d, err_q, err_d, tmo;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d;
  // Rotate requests so bit 0 is the pointer position, then take the lowest set offset.
  assign dbl = {req_valid, req_valid} >> ptr_q;
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        off = UW'(i);
      end
    end
  end
  assign sum = {1'b0, ptr_q} + {1'b0, off};
  assign sel = sum >= (UW+1)'(NUM_USERS) ? UW'(sum - (UW+1)'(NUM_USERS)) : UW'(sum);
  assign req_ready      = (state_q == IDLE && found && !reset) ? NUM_USERS'(1) << sel : '0;
  assign req_resp_valid = (state_q == RESPOND && !reset) ? NUM_USERS'(1) << uid_q : '0;
  assign req_resp_data  = rdata_q;
  assign req_resp_err   = err_q;
  assign mem_valid      = state_q == ISSUE && !reset;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_data       = data_q;
`ifdef MEM_CHANNEL_SCHED_TIMEOUT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= (reset || state_q != WAIT_RESP) ? '0 : cnt_q + 1'b1;
  end
  assign tmo = state_q == WAIT_RESP && cnt_q == 32'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES > 0;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    uid_d = uid_q;
    we_d = we_q;
    addr_d = addr_q;
    data_d = data_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        uid_d = sel;
        we_d = req_we[sel];
        addr_d = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        data_d = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
      end
      ISSUE: state_d = mem_ready ? WAIT_RESP : ISSUE;
      WAIT_RESP: if (mem_resp_valid || tmo) begin
        state_d = RESPOND;
        rdata_d = mem_resp_valid ? mem_resp_data : '0;
        err_d = !mem_resp_valid;
      end
      default: begin
        state_d = IDLE;
        ptr_d = uid_q == UW'(NUM_USERS - 1) ? '0 : uid_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      uid_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      uid_q <= uid_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/mem_channel_sched.md
MEM_CHANNEL_SCHED -- requirements
Module: mem_channel_sched

Interface
REQ-001 SHALL have parameter NUM_USERS, default 4, number of requesters (>=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, response watchdog limit (>=1), used only under REQ-032.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_USERS  per-user request pending.
REQ-008 SHALL have port req_we  input  NUM_USERS  per-user write (1) / read (0).
REQ-009 SHALL have port req_addr  input  NUM_USERS*ADDR_WIDTH  per-user address, user u at bits [u*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port req_data  input  NUM_USERS*DATA_WIDTH  per-user write data, same packing.
REQ-011 SHALL have port req_ready  output  NUM_USERS  one-hot accept strobe.
REQ-012 SHALL have port req_resp_valid  output  NUM_USERS  one-hot completion strobe.
REQ-013 SHALL have port req_resp_data  output  DATA_WIDTH  response data, shared by all users.
REQ-014 SHALL have port req_resp_err  output  1  timeout flag, qualified by req_resp_valid.
REQ-015 SHALL have ports mem_valid output 1, mem_we output 1, mem_addr output ADDR_WIDTH, mem_data output DATA_WIDTH: the channel request.
REQ-016 SHALL have ports mem_ready input 1, mem_resp_valid input 1, mem_resp_data input DATA_WIDTH: channel handshake and response.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT_RESP, RESPOND; one transaction outstanding at a time.
REQ-018 IDLE: if any req_valid, SHALL select the first set bit at or above pointer ptr, wrapping NUM_USERS-1 -> 0, and drive req_ready for that user only, combinationally in the same cycle.
REQ-019 Accept = req_valid[u] & req_ready[u]; on accept SHALL register addr, data, we and index u, then go to ISSUE.
REQ-020 req_ready SHALL be all-zero in every state except IDLE; at most one bit set.
REQ-021 ISSUE: mem_valid SHALL be 1 with the registered fields, held stable until mem_ready=1; on mem_valid & mem_ready SHALL go to WAIT_RESP.
REQ-022 WAIT_RESP: on mem_resp_valid=1 SHALL register mem_resp_data and go to RESPOND; mem_resp_valid SHALL be ignored in all other states.
REQ-023 RESPOND: SHALL pulse req_resp_valid[u] for exactly one cycle with req_resp_data = captured data, set ptr = (u+1) mod NUM_USERS, return to IDLE.
REQ-024 Minimum latency: accept at cycle T, mem_valid at T+1, mem_resp_valid at T+2 (earliest) gives req_resp_valid at T+3; next accept earliest at T+4.
REQ-025 A user whose req_valid is deasserted before accept SHALL simply not be selected; no state change.
REQ-026 For writes (we=1) the memory still returns mem_resp_valid; req_resp_data SHALL carry mem_resp_data unchanged.
REQ-027 req_resp_data and req_resp_err SHALL hold their last values outside RESPOND.

Reset
REQ-028 Reset SHALL be sampled only on rising clk; reset=1 overrides all other inputs that cycle.
REQ-029 On reset: state IDLE, ptr 0, mem_valid 0, mem_we 0, mem_addr 0, mem_data 0, req_ready 0, req_resp_valid 0, req_resp_data 0, req_resp_err 0.
REQ-030 Reset mid-transaction SHALL abandon it without any req_resp_valid; a subsequent late mem_resp_valid SHALL be ignored (state IDLE).

Configuration
REQ-031 Without MEM_CHANNEL_SCHED_TIMEOUT_EN: WAIT_RESP waits indefinitely; req_resp_err SHALL be constant 0.
REQ-032 With MEM_CHANNEL_SCHED_TIMEOUT_EN: counter cleared on entry to WAIT_RESP, increments each WAIT_RESP cycle; if it reaches TIMEOUT_CYCLES without mem_resp_valid, SHALL go to RESPOND with req_resp_err=1, req_resp_data=0; mem_resp_valid in the same cycle as expiry SHALL win (err=0).

Verification
REQ-033 Reset, then req_valid=4'b0100, addr 0x100, mem_ready=1, resp 0xDEADBEEF one cycle after handshake -> req_ready=4'b0100 at T, mem_valid/addr 0x100 at T+1, req_resp_valid=4'b0100 with 0xDEADBEEF at T+3, ptr=3.
REQ-034 All four users valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two req_ready bits set.
REQ-035 mem_ready held 0 for 5 cycles in ISSUE -> mem_valid/addr/data/we stable all 5 cycles; transition on cycle mem_ready=1.
REQ-036 ptr=3, only user 1 valid -> wrap search grants user 1; ptr becomes 2 after response.
REQ-037 Reset asserted in WAIT_RESP, mem_resp_valid arrives 2 cycles later -> no req_resp_valid, all outputs at REQ-029 values.
REQ-038 With macro, TIMEOUT_CYCLES=4, memory never responds -> req_resp_valid for owner with req_resp_err=1, data 0, 4 cycles after WAIT_RESP entry; without macro, still in WAIT_RESP after 1000 cycles.
